// File: rtl/sys_bridge_n.sv
// sys_bridge_n: CPU-to-peripheral bridge.
// Decodes a CPU request against per-slave address windows and runs a
// strobe/ack transaction with the selected slave. Unmapped or unanswered
// accesses complete with an error. Peripheral interrupt lines are merged
// into the hwint vector, with each line either level-following or edge-latched.
//
// Handshake: the CPU raises pr_req and holds it, with address, data and byte
// enables stable, until pr_ready pulses for one cycle. A slave sees s_stb[i]
// held high for as many cycles as it needs. It answers by raising s_ack[i]
// for one cycle with s_rd[i] valid. Acks from slaves not being strobed are
// ignored.
module sys_bridge_n #(
  parameter int                 NSLV      = 5,
  parameter logic [NSLV*32-1:0] SLV_BASE  = {32'h0000_7F40, 32'h0000_7F30,
                                             32'h0000_7F10, 32'h0000_7F00,
                                             32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_LIMIT = {32'h0000_7F4F, 32'h0000_7F33,
                                             32'h0000_7F2B, 32'h0000_7F0B,
                                             32'h0000_2FFF},
  parameter int                 TIMEOUT   = 16,
  parameter int                 NIRQ      = 6,
  parameter logic [NIRQ-1:0]    IRQ_EDGE  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pr_req,
  input  logic [31:0]          pr_addr,
  input  logic [31:0]          pr_wd,
  input  logic [3:0]           pr_byteen,
  output logic [31:0]          pr_rd,
  output logic                 pr_ready,
  output logic                 pr_err,
  output logic                 pr_busy,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wd,
  output logic [NSLV*4-1:0]    s_byteen,
  output logic [NSLV-1:0]      s_stb,
  input  logic [NSLV*32-1:0]   s_rd,
  input  logic [NSLV-1:0]      s_ack,
  input  logic [NIRQ-1:0]      irq_in,
  input  logic [NIRQ-1:0]      irq_clr,
  output logic [NIRQ-1:0]      hwint,
  output logic [1:0]           dbg_state
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_addr, r_wd, r_rd;
  logic [3:0]      r_be;
  logic [NSLV-1:0] r_sel;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [NIRQ-1:0] r_irq_prev, r_pend, r_hwint;

  logic [NSLV-1:0] w_sel;
  logic            w_hit;
  logic            w_ack;
  logic [31:0]     w_rd;
  logic            w_timeout;
  logic [NIRQ-1:0] w_rise, w_pend_nxt;

  // Address decode: first (lowest-index) window containing pr_addr wins.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!w_hit && (pr_addr >= SLV_BASE[32*i +: 32]) &&
          (pr_addr <= SLV_LIMIT[32*i +: 32])) begin
        w_sel[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
  end

  // Return path: only the latched slave's ack and read data are observed.
  always_comb begin
    w_ack = |(s_ack & r_sel);
    w_rd  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_sel[i]) w_rd = w_rd | s_rd[32*i +: 32];
    end
  end

  assign w_timeout = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic; requests are only accepted in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (pr_req) w_state_nxt = w_hit ? ST_ACCESS : ST_DONE;
      ST_ACCESS: if (w_ack || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; strobe and byte enables are decoded straight from the state
  // flop, so an asynchronous reset removes them immediately.
  always_comb begin
    s_stb    = (r_state == ST_ACCESS) ? r_sel : '0;
    s_byteen = '0;
    for (int i = 0; i < NSLV; i++) begin
      if ((r_state == ST_ACCESS) && r_sel[i]) s_byteen[4*i +: 4] = r_be;
    end
    pr_ready  = (r_state == ST_DONE);
    pr_busy   = (r_state != ST_IDLE);
    dbg_state = r_state;
  end

  // Transaction datapath: latch the request, count waits, capture the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_wd   <= '0;
      r_be   <= '0;
      r_sel  <= '0;
      r_cnt  <= '0;
      r_rd   <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pr_req && w_hit) begin
            r_addr <= pr_addr;
            r_wd   <= pr_wd;
            r_be   <= pr_byteen;
            r_sel  <= w_sel;
            r_cnt  <= '0;
          end else if (pr_req) begin
            r_rd   <= '0;
            r_err  <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (w_ack) begin
            r_rd  <= w_rd;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_rd  <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_addr = r_addr;
  assign s_wd   = r_wd;
  assign pr_rd  = r_rd;
  assign pr_err = r_err;

  // Edge-latched lines use the next pending value so both line kinds lag by one cycle.
  assign w_rise     = irq_in & ~r_irq_prev;
  assign w_pend_nxt = ((r_pend & ~irq_clr) | w_rise) & IRQ_EDGE;

  // Interrupt sampling, pending latches and the registered hwint vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_hwint    <= '0;
    end else begin
      r_irq_prev <= irq_in;
      r_pend     <= w_pend_nxt;
      r_hwint    <= w_pend_nxt | (irq_in & ~IRQ_EDGE);
    end
  end

  assign hwint = r_hwint;

endmodule
